// File: rtl/sd_pkg.sv
// Shared SD host constants: CRC widths, CRC polynomials and command frame sizes.
package sd_pkg;

  localparam int CMD_CRCW = 7;
  localparam int DAT_CRCW = 16;

  localparam logic [CMD_CRCW-1:0] CRC7_POLY  = 7'h09;
  localparam logic [DAT_CRCW-1:0] CRC16_POLY = 16'h1021;

  localparam int CMD_FRAME_W   = 48;
  localparam int CMD_PAYLOAD_W = 40;

endpackage

// File: rtl/sd_crc_if.sv
// CMD/DAT CRC bus between the SD command/data state machines and sd_crc.
interface sd_crc_if
  import sd_pkg::*;
#(
  parameter int CMD_CRCW  = sd_pkg::CMD_CRCW,
  parameter int DAT_CRCW  = sd_pkg::DAT_CRCW,
  parameter int DAT_LANES = 4
);
  logic                          cmd_clr;
  logic                          cmd_en;
  logic                          cmd_data;
  logic [CMD_CRCW-1:0]           cmd_crc;
  logic                          cmd_ok;
  logic                          dat_clr;
  logic                          dat_en;
  logic [DAT_LANES-1:0]          dat_data;
  logic [DAT_LANES*DAT_CRCW-1:0] dat_crc;
  logic [DAT_LANES-1:0]          dat_ok;

  modport master (
    output cmd_clr, cmd_en, cmd_data, dat_clr, dat_en, dat_data,
    input  cmd_crc, cmd_ok, dat_crc, dat_ok
  );

  modport slave (
    input  cmd_clr, cmd_en, cmd_data, dat_clr, dat_en, dat_data,
    output cmd_crc, cmd_ok, dat_crc, dat_ok
  );
endinterface

// File: rtl/sd_crc_lfsr.sv
// Generic MSB-first serial CRC accumulator: init 0, no reflection, no final XOR.
module sd_crc_lfsr #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = 7'h09
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             data,
  output logic [WIDTH-1:0] crc
);
  logic             fb;
  logic [WIDTH-1:0] crc_next;

  assign fb       = data ^ crc[WIDTH-1];
  assign crc_next = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

  // clr wins over en, so a bit offered in a clear cycle is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        crc <= '0;
    else if (clr)    crc <= '0;
    else if (en)     crc <= crc_next;
  end
endmodule

// File: rtl/sd_crc.sv
// SD CRC engine: one CRC7 on CMD plus one CRC16 per DAT lane.
// Define SD_CRC_WIDE_BUS_EN for all DAT lanes (4-bit bus); otherwise only lane 0 exists.
module sd_crc
  import sd_pkg::*;
#(
  parameter int                  CMD_CRCW  = sd_pkg::CMD_CRCW,
  parameter logic [CMD_CRCW-1:0] CMD_POLY  = sd_pkg::CRC7_POLY,
  parameter int                  DAT_CRCW  = sd_pkg::DAT_CRCW,
  parameter logic [DAT_CRCW-1:0] DAT_POLY  = sd_pkg::CRC16_POLY,
  parameter int                  DAT_LANES = 4
) (
  input logic     clk,
  input logic     rst,
  sd_crc_if.slave bus
);
  logic [CMD_CRCW-1:0]           cmd_crc_q;
  logic [DAT_LANES*DAT_CRCW-1:0] dat_crc_all;

  sd_crc_lfsr #(.WIDTH(CMD_CRCW), .POLY(CMD_POLY)) u_cmd (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.cmd_clr),
    .en   (bus.cmd_en),
    .data (bus.cmd_data),
    .crc  (cmd_crc_q)
  );

`ifdef SD_CRC_WIDE_BUS_EN
  for (genvar i = 0; i < DAT_LANES; i++) begin : g_lane
    sd_crc_lfsr #(.WIDTH(DAT_CRCW), .POLY(DAT_POLY)) u_dat (
      .clk  (clk),
      .rst  (rst),
      .clr  (bus.dat_clr),
      .en   (bus.dat_en),
      .data (bus.dat_data[i]),
      .crc  (dat_crc_all[i*DAT_CRCW +: DAT_CRCW])
    );
  end
`else
  sd_crc_lfsr #(.WIDTH(DAT_CRCW), .POLY(DAT_POLY)) u_dat0 (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.dat_clr),
    .en   (bus.dat_en),
    .data (bus.dat_data[0]),
    .crc  (dat_crc_all[DAT_CRCW-1:0])
  );

  // 1-bit bus mode: upper lanes read as a permanently clean, empty CRC
  if (DAT_LANES > 1) begin : g_narrow
    logic unused_dat_hi;
    assign unused_dat_hi = ^bus.dat_data[DAT_LANES-1:1];
    assign dat_crc_all[DAT_LANES*DAT_CRCW-1:DAT_CRCW] = '0;
  end
`endif

  assign bus.cmd_crc = cmd_crc_q;
  assign bus.cmd_ok  = (cmd_crc_q == '0);
  assign bus.dat_crc = dat_crc_all;

  always_comb begin
    bus.dat_ok = '0;
    for (int i = 0; i < DAT_LANES; i++)
      bus.dat_ok[i] = (dat_crc_all[i*DAT_CRCW +: DAT_CRCW] == '0);
  end
endmodule

// File: tb/tb_sd_crc.sv
// Self-checking bench for sd_crc: known SD CRC vectors plus randomized traffic
// checked against a polynomial long-division reference model.
module tb_sd_crc;
  import sd_pkg::*;

`ifdef SD_CRC_WIDE_BUS_EN
  localparam int IMPL = 4;
`else
  localparam int IMPL = 1;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  bit cmd_q[$];
  bit dat_q[4][$];

  sd_crc_if bus ();

  sd_crc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of M(x)*x^w divided by g(x), g given with its x^w term
  function automatic logic [15:0] crc_ref(input bit msg[$], input int w, input logic [16:0] g);
    bit bb[$];
    logic [15:0] r;
    bb = msg;
    for (int k = 0; k < w; k++) bb.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (bb[i])
        for (int j = 0; j <= w; j++) bb[i+j] = bb[i+j] ^ g[w-j];
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = bb[msg.size()+j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e;
    logic [3:0]  eok;
    e = crc_ref(cmd_q, 7, 17'h00089);
    chk({tag, ".cmd_crc"}, {57'b0, bus.cmd_crc}, {48'b0, e});
    chk({tag, ".cmd_ok"}, {63'b0, bus.cmd_ok}, {63'b0, e == 16'h0});
    eok = 4'hF;
    for (int i = 0; i < 4; i++) begin
      e = (i < IMPL) ? crc_ref(dat_q[i], 16, 17'h11021) : 16'h0;
      eok[i] = (e == 16'h0);
      chk($sformatf("%s.dat_crc%0d", tag, i), {48'b0, bus.dat_crc[i*16 +: 16]}, {48'b0, e});
    end
    chk({tag, ".dat_ok"}, {60'b0, bus.dat_ok}, {60'b0, eok});
  endtask

  // Called at a negedge; applies inputs across one rising edge and returns at the next negedge
  task automatic step(input logic cc, input logic ce, input logic cd,
                      input logic dc, input logic de, input logic [3:0] dd);
    bus.cmd_clr  = cc;
    bus.cmd_en   = ce;
    bus.cmd_data = cd;
    bus.dat_clr  = dc;
    bus.dat_en   = de;
    bus.dat_data = dd;
    @(posedge clk);
    if (cc) cmd_q.delete();
    else if (ce) cmd_q.push_back(cd);
    for (int i = 0; i < 4; i++) begin
      if (dc) dat_q[i].delete();
      else if (de) dat_q[i].push_back(dd[i]);
    end
    @(negedge clk);
  endtask

  task automatic shift_cmd(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i], 1'b0, 1'b0, 4'h0);
  endtask

  task automatic shift_dat_byte(input logic [7:0] b);
    logic [2:0] hi;
    for (int k = 7; k >= 0; k--) begin
      hi = 3'($urandom);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {hi, b[k]});
    end
  endtask

  initial begin
    string s;
    logic [6:0] held;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.cmd_clr = 1'b0; bus.cmd_en = 1'b0; bus.cmd_data = 1'b0;
    bus.dat_clr = 1'b0; bus.dat_en = 1'b0; bus.dat_data = 4'h0;
    repeat (2) @(negedge clk);

    chk("rst.cmd_crc", {57'b0, bus.cmd_crc}, 64'h0);
    chk("rst.cmd_ok", {63'b0, bus.cmd_ok}, 64'h1);
    chk("rst.dat_crc", bus.dat_crc, 64'h0);
    chk("rst.dat_ok", {60'b0, bus.dat_ok}, 64'hF);
    rst = 1'b1;
    @(negedge clk);

    // CMD0 frame, then its own CRC appended
    shift_cmd(64'h40_0000_0000, CMD_PAYLOAD_W);
    chk("cmd0.crc", {57'b0, bus.cmd_crc}, 64'h4A);
    check_all("cmd0");
    shift_cmd(64'b1001010, 7);
    chk("cmd0.rx_ok", {63'b0, bus.cmd_ok}, 64'h1);
    check_all("cmd0rx");

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    shift_cmd(64'h51_0000_0000, CMD_PAYLOAD_W);
    chk("cmd17.crc", {57'b0, bus.cmd_crc}, 64'h2A);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    shift_cmd(64'h48_0000_01AA, CMD_PAYLOAD_W);
    chk("cmd8.crc", {57'b0, bus.cmd_crc}, 64'h43);
    check_all("cmd8");

    // 512 bytes of 0xFF on lane 0, random bits on the other lanes
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    for (int n = 0; n < 512; n++) shift_dat_byte(8'hFF);
    chk("dat.ff512", {48'b0, bus.dat_crc[15:0]}, 64'h7FA1);
    chk("cmd.hold_during_dat", {57'b0, bus.cmd_crc}, 64'h43);
    check_all("dat512");

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    s = "123456789";
    for (int n = 0; n < s.len(); n++) shift_dat_byte(s[n]);
    chk("dat.check", {48'b0, bus.dat_crc[15:0]}, 64'h31C3);
    check_all("dat123");

    // Randomized traffic on both groups with sparse clears
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0), 1'($urandom),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0), 4'($urandom));
      if (n % 40 == 39) check_all($sformatf("rnd%0d", n));
    end

    // clr and en together on a nonzero accumulator: bit is lost
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    shift_cmd(64'h40_0000_0000, CMD_PAYLOAD_W);
    chk("clren.pre", {57'b0, bus.cmd_crc}, 64'h4A);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("clren.cmd_crc", {57'b0, bus.cmd_crc}, 64'h0);
    check_all("clren");

    // Hold with en low, data wiggling
    shift_cmd(64'h51_0000_0000, CMD_PAYLOAD_W);
    held = 7'h2A;
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 4'($urandom));
      chk($sformatf("hold%0d", n), {57'b0, bus.cmd_crc}, {57'b0, held});
    end

    // Asynchronous reset between edges, mid-frame
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1, 4'($urandom));
    bus.cmd_en = 1'b0;
    bus.dat_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    cmd_q.delete();
    for (int i = 0; i < 4; i++) dat_q[i].delete();
    chk("arst.cmd_crc", {57'b0, bus.cmd_crc}, 64'h0);
    chk("arst.dat_crc", bus.dat_crc, 64'h0);
    chk("arst.dat_ok", {60'b0, bus.dat_ok}, 64'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    shift_cmd(64'h40_0000_0000, CMD_PAYLOAD_W);
    chk("arst.cmd0", {57'b0, bus.cmd_crc}, 64'h4A);

`ifndef SD_CRC_WIDE_BUS_EN
    // Upper lanes must ignore their data in 1-bit bus mode
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {3'($urandom) | 3'b001, 1'($urandom)});
      chk($sformatf("narrow.crc%0d", n), {16'b0, bus.dat_crc[63:16]}, 64'h0);
      chk($sformatf("narrow.ok%0d", n), {61'b0, bus.dat_ok[3:1]}, 64'h7);
    end
`endif
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
